// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution engine.
package conv_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 48;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_WAIT_LOW
  } state_t;

  function automatic int padded_size(input int fm_size, input int padding);
    return fm_size + 2 * padding;
  endfunction

  function automatic int out_size(input int fm_size, input int kernel_size,
                                  input int padding, input int stride);
    return (padded_size(fm_size, padding) - kernel_size) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_block_if.sv
// Start/result bundle between the layer controller and conv_block.
interface conv_block_if;
  import conv_pkg::*;

  logic                     go;
  logic                     done;
  logic signed [ACC_W-1:0]  conv_result;

  modport master (output go, input done, input conv_result);
  modport slave  (input go, output done, output conv_result);
endinterface

// File: rtl/conv_pe.sv
// One registered multiply-add stage of the MAC cascade (one DSP slice).
module conv_pe
  import conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  p_in,
  output logic signed [ACC_W-1:0]  p_out
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) p_out <= '0;
    else     p_out <= p_in + ACC_W'(prod);
  end

endmodule

// File: rtl/conv_block.sv
// Fixed-function 2-D convolution: window generator, skewed operands and a
// K*K systolic MAC cascade producing one result per cycle in raster order.
module conv_block
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 4,
  parameter int PADDING     = 0,
  parameter int STRIDE      = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_go,
  output logic                    o_done,
  output logic signed [ACC_W-1:0] o_conv_result
);

  localparam int P  = padded_size(FM_SIZE, PADDING);
  localparam int O  = out_size(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE);
  localparam int K2 = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CW = (O > 1) ? $clog2(O) : 1;

  if ((P < KERNEL_SIZE) || (((P - KERNEL_SIZE) % STRIDE) != 0)) begin : g_bad_cfg
    $error("conv_block: padded size minus kernel must be a non-negative multiple of STRIDE");
  end

  function automatic logic signed [DATA_W-1:0] fm_at(input int prow, input int pcol);
    int r;
    int c;
    r = prow - PADDING;
    c = pcol - PADDING;
    if (r < 0 || c < 0 || r >= FM_SIZE || c >= FM_SIZE) return '0;
    return DATA_W'(r * FM_SIZE + c + 1);
  endfunction

  state_t                  state;
  logic [CW-1:0]           orow;
  logic [CW-1:0]           ocol;
  logic                    issue;
  logic                    last_win;
  logic [K2-1:0]           vld;
  logic signed [ACC_W-1:0] pe_out [K2];

  assign issue    = (state == ST_RUN);
  assign last_win = (orow == CW'(O - 1)) && (ocol == CW'(O - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      orow  <= '0;
      ocol  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          orow <= '0;
          ocol <= '0;
          if (i_go) state <= ST_RUN;
        end
        ST_RUN: begin
          if (ocol == CW'(O - 1)) begin
            ocol <= '0;
            orow <= orow + 1'b1;
          end else begin
            ocol <= ocol + 1'b1;
          end
          if (last_win) state <= ST_DRAIN;
        end
        ST_DRAIN:    if (vld == '0) state <= ST_WAIT_LOW;
        ST_WAIT_LOW: if (!i_go)     state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Tap k sees its window operand k cycles late so it meets the partial sum
  // rippling down the cascade; weights are constant and need no skew.
  for (genvar k = 0; k < K2; k++) begin : g_tap
    localparam int I = k / KERNEL_SIZE;
    localparam int J = k % KERNEL_SIZE;
    localparam logic signed [DATA_W-1:0] WGT = DATA_W'(k + 1);

    logic signed [DATA_W-1:0] fm_now;
    logic signed [DATA_W-1:0] fm_skew;
    logic signed [ACC_W-1:0]  p_in;

    assign fm_now = fm_at(int'(orow) * STRIDE + I, int'(ocol) * STRIDE + J);

    if (k == 0) begin : g_head
      assign fm_skew = fm_now;
      assign p_in    = '0;
    end else begin : g_dly
      logic signed [DATA_W-1:0] dly [k];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int unsigned d = 0; d < k; d++) dly[d] <= '0;
        end else begin
          dly[0] <= fm_now;
          for (int unsigned d = 1; d < k; d++) dly[d] <= dly[d-1];
        end
      end

      assign fm_skew = dly[k-1];
      assign p_in    = pe_out[k-1];
    end

    conv_pe u_pe (
      .clk   (i_clk),
      .rst   (i_rst),
      .a     (WGT),
      .b     (fm_skew),
      .p_in  (p_in),
      .p_out (pe_out[k])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld           <= '0;
      o_done        <= 1'b0;
      o_conv_result <= '0;
    end else begin
      vld    <= (vld << 1) | K2'(issue);
      o_done <= vld[K2-1];
      if (vld[K2-1]) o_conv_result <= pe_out[K2-1];
    end
  end

endmodule

// File: tb/tb_conv_block.sv
// Scoreboard bench for conv_block: default, padded and strided configurations.
module tb_conv_block;
  import conv_pkg::*;

  typedef struct {
    longint res;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_def = 0;
  int   n_pad = 0;
  int   n_s2 = 0;
  exp_t q_def[$];
  exp_t q_pad[$];
  exp_t q_s2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_block_if if_def ();
  conv_block_if if_pad ();
  conv_block_if if_s2 ();

  conv_block #(.KERNEL_SIZE(3), .FM_SIZE(4), .PADDING(0), .STRIDE(1)) u_def (
    .i_clk(clk), .i_rst(rst), .i_go(if_def.go),
    .o_done(if_def.done), .o_conv_result(if_def.conv_result)
  );

  conv_block #(.KERNEL_SIZE(3), .FM_SIZE(4), .PADDING(1), .STRIDE(1)) u_pad (
    .i_clk(clk), .i_rst(rst), .i_go(if_pad.go),
    .o_done(if_pad.done), .o_conv_result(if_pad.conv_result)
  );

  conv_block #(.KERNEL_SIZE(3), .FM_SIZE(5), .PADDING(0), .STRIDE(2)) u_s2 (
    .i_clk(clk), .i_rst(rst), .i_go(if_s2.go),
    .o_done(if_s2.done), .o_conv_result(if_s2.conv_result)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(input int fm, input int k, input int pad, input int s,
                                   input int orow, input int ocol);
    longint acc = 0;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        int r = orow * s + i - pad;
        int c = ocol * s + j - pad;
        if (r >= 0 && c >= 0 && r < fm && c < fm)
          acc += longint'(i * k + j + 1) * longint'(r * fm + c + 1);
      end
    end
    return acc;
  endfunction

  // Pushes one run's expected results; called on a negedge just before go rises.
  task automatic start_def();
    longint vals [4] = '{348, 393, 528, 573};
    int c0 = cyc + 1;
    for (int n = 0; n < 4; n++) q_def.push_back('{vals[n], c0 + 10 + n});
    if_def.go = 1'b1;
  endtask

  task automatic start_model(input int id, input int fm, input int pad, input int s);
    int o  = out_size(fm, 3, pad, s);
    int c0 = cyc + 1;
    for (int n = 0; n < o * o; n++) begin
      exp_t e;
      e.res = model(fm, 3, pad, s, n / o, n % o);
      e.cyc = c0 + 10 + n;
      if (id == 0) q_pad.push_back(e);
      else         q_s2.push_back(e);
    end
    if (id == 0) if_pad.go = 1'b1;
    else         if_s2.go  = 1'b1;
  endtask

  task automatic wait_empty(input int limit);
    for (int i = 0; i < limit && (q_def.size() + q_pad.size() + q_s2.size()) > 0; i++)
      @(posedge clk);
    check_eq("drain_timeout", q_def.size() + q_pad.size() + q_s2.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if_def.done) begin
      n_def++;
      if (q_def.size() == 0) check_eq("def_spurious", longint'(if_def.done), 0);
      else begin
        e = q_def.pop_front();
        check_eq("def_res", if_def.conv_result, e.res);
        check_eq("def_lat", cyc, e.cyc);
      end
    end
    if (if_pad.done) begin
      n_pad++;
      if (q_pad.size() == 0) check_eq("pad_spurious", longint'(if_pad.done), 0);
      else begin
        e = q_pad.pop_front();
        check_eq("pad_res", if_pad.conv_result, e.res);
        check_eq("pad_lat", cyc, e.cyc);
      end
    end
    if (if_s2.done) begin
      n_s2++;
      if (q_s2.size() == 0) check_eq("s2_spurious", longint'(if_s2.done), 0);
      else begin
        e = q_s2.pop_front();
        check_eq("s2_res", if_s2.conv_result, e.res);
        check_eq("s2_lat", cyc, e.cyc);
      end
    end
  end

  initial begin
    if_def.go = 1'b0;
    if_pad.go = 1'b0;
    if_s2.go  = 1'b0;
    #150;
    check_eq("rst_done", longint'(if_def.done), 0);
    check_eq("rst_res", if_def.conv_result, 0);
    check_eq("rst_pad_res", if_pad.conv_result, 0);
    rst = 1'b0;

    repeat (20) @(negedge clk);
    check_eq("idle_res", if_def.conv_result, 0);
    check_eq("idle_cnt", n_def, 0);

    start_def();
    wait_empty(200);
    repeat (30) @(negedge clk);
    check_eq("def_burst_cnt", n_def, 4);
    check_eq("def_hold", if_def.conv_result, 573);

    if_def.go = 1'b0;
    repeat (3) @(negedge clk);
    start_def();
    wait_empty(200);
    repeat (5) @(negedge clk);
    check_eq("def_rerun_cnt", n_def, 8);
    if_def.go = 1'b0;

    repeat (3) @(negedge clk);
    start_def();
    for (int i = 0; i < 100 && n_def < 10; i++) @(posedge clk);
    check_eq("mid_two_strobes", n_def, 10);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_done", longint'(if_def.done), 0);
    check_eq("mid_rst_res", if_def.conv_result, 0);
    q_def.delete();
    if_def.go = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("mid_no_more", n_def, 10);

    start_def();
    wait_empty(200);
    repeat (5) @(negedge clk);
    check_eq("post_rst_cnt", n_def, 14);
    if_def.go = 1'b0;

    start_model(0, 4, 1, 1);
    start_model(1, 5, 0, 2);
    wait_empty(400);
    repeat (10) @(negedge clk);
    check_eq("pad_cnt", n_pad, 16);
    check_eq("s2_cnt", n_s2, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
